i2c_arbiter: RTL
================

# i2c_arbiter

Shares the single `i2c_master` instance between several independent requesters, such as the OLED init/command sequencer and a framebuffer data writer. Each requester presents one control byte (`0x00` = command, `0x40` = data) plus one payload byte. The arbiter grants in round-robin order, drives the master's enable/address/data inputs, and waits for the master's done. It then acknowledges the requester and enforces an inter-transfer gap and a hang timeout.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters; legal range 2..4.
- `GAP_CYCLES`, 16: idle cycles between transfers; legal range 1..255.
- `TIMEOUT_CYCLES`, 320000: cycles allowed from `m_enable` rise to `m_done` (10 ms at 32 MHz); must be <2^24.

Ports:
- `clk_32M`  in  1  system clock; the block uses this single clock only.
- `rst`  in  1  reset; synchronous, active-high.
- `req`  in  NUM_REQ  request level per requester.
- `req_ctrl`  in  NUM_REQ*8  control byte per requester; requester i uses bits [8i+7:8i].
- `req_data`  in  NUM_REQ*8  payload byte per requester, same packing as `req_ctrl`.
- `ack`  out  NUM_REQ  one-cycle pulse to the served requester at transfer end.
- `ack_err`  out  1  valid with `ack`; 1 means the transfer timed out.
- `timeout_err`  out  1  sticky flag, set by any timeout; cleared only by `rst`.
- `busy`  out  1  high whenever the block is not in IDLE.
- `grant_id`  out  2  index of the current or last served requester.
- `m_enable`  out  1  to `i2c_master` `enable`.
- `m_reg_addr`  out  8  to `i2c_master` `reg_addr`.
- `m_data`  out  8  to `i2c_master` `data_in`.
- `m_done`  in  1  from `i2c_master` `done`; a one-cycle pulse when a transfer completes.

## Operation
States are IDLE, BUSY and GAP.

- **Reset:** all outputs are 0, the state is IDLE, the timer and gap counter are 0, and the round-robin pointer is `NUM_REQ-1`, so requester 0 has first priority.
- **IDLE:**
  - If `req` is non-zero, the winner is the first set bit scanning from `ptr+1` upward, modulo `NUM_REQ`.
  - On the same edge, load `m_reg_addr`/`m_data` from the winner's slices, set `grant_id` to the winner, set `ptr` to the winner, set `m_enable` to 1, clear the timer, and go to BUSY.
  - If `req` is zero, hold all outputs.
- **BUSY:** `m_enable` stays 1, `m_reg_addr`/`m_data` stay frozen, and the timer increments every cycle.
  - On `m_done`=1: set `m_enable` to 0, pulse `ack[grant_id]` for one cycle with `ack_err`=0, load the gap counter, and go to GAP.
  - When the timer reaches `TIMEOUT_CYCLES-1` with no `m_done`: set `m_enable` to 0, pulse `ack[grant_id]` with `ack_err`=1, set `timeout_err`, and go to GAP.
  - If both conditions occur in the same cycle, `m_done` wins: `ack_err`=0 and `timeout_err` is unchanged.
- **GAP:** `m_enable`=0. Count `GAP_CYCLES` cycles, then go to IDLE; `req` is ignored during GAP.
- **Request held:** a requester keeps `req` and its bytes stable until its `ack`. The arbiter samples the bytes only at grant time, so changes after the grant have no effect.
- **Early release:** if `req` drops during BUSY, the transfer still completes and `ack` is still pulsed. The requester must ignore that pulse.
- **Repeat grants:** a requester that holds `req` through `ack` is treated as a new request in the next IDLE. It wins again only if no other requester is pending.
- **Reset mid-transfer:** `rst` during BUSY or GAP forces IDLE, `m_enable`=0, no `ack`, and `ptr` back to `NUM_REQ-1`. No transfer state survives.
- **Fixed values:** `m_reg_addr` carries the requester's control byte unmodified. `Send`, `HS` and `burst_write` are tied at the instantiation level, not by this block.

## Timing
- Grant latency: `req` seen high at edge N (in IDLE) gives `m_enable`=1 after edge N. That is 1 cycle.
- Ack latency: `m_done` sampled high at edge M gives `ack`=1 and `m_enable`=0 after edge M; `ack` falls after edge M+1.
- Back-to-back spacing: the earliest next `m_enable` rise comes `GAP_CYCLES`+1 cycles after the `ack` edge (GAP plus the IDLE grant cycle).
- Timeout: `ack_err` fires exactly `TIMEOUT_CYCLES` cycles after `m_enable` rises. The timer is 24 bits and never wraps, because it stops at the limit.
- `busy` is registered: it equals 1 from the grant edge through the last GAP cycle.
- All outputs are registered; there are no combinational paths from input to output.

## Test plan
- **Single grant:** `req`=01, `req_ctrl[7:0]`=0x00, `req_data[7:0]`=0xAE. `m_enable` rises 1 cycle later with `m_reg_addr`=0x00 and `m_data`=0xAE. Pulse `m_done` 50 cycles later: `ack`=01 for one cycle, `ack_err`=0, and the next grant cannot occur for 17 cycles.
- **Round-robin:** `req`=11 held continuously, `m_done` returned 10 cycles after each enable. The grant order is 0,1,0,1 and `grant_id` alternates.
- **Timeout:** use `TIMEOUT_CYCLES`=100 and never pulse `m_done`. `ack`=01 with `ack_err`=1 arrives exactly 100 cycles after the `m_enable` rise, and `timeout_err` stays 1 until `rst`.
- **Simultaneous done/timeout:** pulse `m_done` in the cycle where the timer equals 99. `ack_err`=0 and `timeout_err` stays 0.
- **Byte change after grant:** change `req_data` from 0xAE to 0x55 after the grant. `m_data` stays 0xAE until GAP.
- **Reset mid-BUSY:** assert `rst` 5 cycles after the grant. The next cycle shows `m_enable`=0, `busy`=0 and no `ack`. After release, `req`=11 grants requester 0 first.

Source files
------------

// File: rtl/i2c_arbiter.sv
// i2c_arbiter: round-robin sharing of one i2c_master among NUM_REQ
// requesters, with a fixed inter-transfer gap and a hang timeout.
module i2c_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 320000
) (
    input  logic                 clk_32M,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*8-1:0] req_ctrl,
    input  logic [NUM_REQ*8-1:0] req_data,
    output logic [NUM_REQ-1:0]   ack,
    output logic                 ack_err,
    output logic                 timeout_err,
    output logic                 busy,
    output logic [1:0]           grant_id,
    output logic                 m_enable,
    output logic [7:0]           m_reg_addr,
    output logic [7:0]           m_data,
    input  logic                 m_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_GAP
    } state_t;

    localparam logic [23:0] TMAX    = 24'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]  GLOAD   = 8'(GAP_CYCLES);
    localparam logic [1:0]  PTR_RST = 2'(NUM_REQ - 1);

    state_t state, state_nxt;

    logic [23:0]        timer, timer_nxt;
    logic [7:0]         gap_cnt, gap_cnt_nxt;
    logic [1:0]         ptr, ptr_nxt;
    logic [NUM_REQ-1:0] ack_nxt;
    logic               ack_err_nxt;
    logic               terr_nxt;
    logic               busy_nxt;
    logic [1:0]         gid_nxt;
    logic               en_nxt;
    logic [7:0]         addr_nxt;
    logic [7:0]         data_nxt;

    logic [3:0]  req_pad;
    logic [31:0] ctrl_pad;
    logic [31:0] data_pad;
    logic [3:0]  ack_pad;
    logic [2:0]  cand;
    logic [1:0]  win;
    logic        found;

    always_comb begin
        req_pad                  = '0;
        req_pad[NUM_REQ-1:0]     = req;
        ctrl_pad                 = '0;
        ctrl_pad[NUM_REQ*8-1:0]  = req_ctrl;
        data_pad                 = '0;
        data_pad[NUM_REQ*8-1:0]  = req_data;
        ack_pad                  = 4'b0001 << grant_id;
    end

    // First pending requester after ptr, wrapping at NUM_REQ.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = 3'(ptr) + 3'(k);
            if (cand >= 3'(NUM_REQ)) begin
                cand = cand - 3'(NUM_REQ);
            end
            if (!found && req_pad[cand[1:0]]) begin
                found = 1'b1;
                win   = cand[1:0];
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        timer_nxt   = timer;
        gap_cnt_nxt = gap_cnt;
        ptr_nxt     = ptr;
        ack_nxt     = '0;
        ack_err_nxt = 1'b0;
        terr_nxt    = timeout_err;
        gid_nxt     = grant_id;
        en_nxt      = m_enable;
        addr_nxt    = m_reg_addr;
        data_nxt    = m_data;

        unique case (state)
            S_IDLE: begin
                if (found) begin
                    addr_nxt  = ctrl_pad[{win, 3'b000} +: 8];
                    data_nxt  = data_pad[{win, 3'b000} +: 8];
                    gid_nxt   = win;
                    ptr_nxt   = win;
                    en_nxt    = 1'b1;
                    timer_nxt = '0;
                    state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                en_nxt = 1'b1;
                // m_done takes precedence over a coincident timeout
                if (m_done) begin
                    en_nxt      = 1'b0;
                    ack_nxt     = ack_pad[NUM_REQ-1:0];
                    gap_cnt_nxt = GLOAD;
                    state_nxt   = S_GAP;
                end else if (timer == TMAX) begin
                    en_nxt      = 1'b0;
                    ack_nxt     = ack_pad[NUM_REQ-1:0];
                    ack_err_nxt = 1'b1;
                    terr_nxt    = 1'b1;
                    gap_cnt_nxt = GLOAD;
                    state_nxt   = S_GAP;
                end else begin
                    timer_nxt = timer + 24'd1;
                end
            end
            S_GAP: begin
                en_nxt = 1'b0;
                if (gap_cnt <= 8'd1) begin
                    gap_cnt_nxt = '0;
                    state_nxt   = S_IDLE;
                end else begin
                    gap_cnt_nxt = gap_cnt - 8'd1;
                end
            end
            default: begin
                en_nxt    = 1'b0;
                state_nxt = S_IDLE;
            end
        endcase

        busy_nxt = (state_nxt != S_IDLE);
    end

    always_ff @(posedge clk_32M) begin
        if (rst) begin
            state       <= S_IDLE;
            timer       <= '0;
            gap_cnt     <= '0;
            ptr         <= PTR_RST;
            ack         <= '0;
            ack_err     <= 1'b0;
            timeout_err <= 1'b0;
            busy        <= 1'b0;
            grant_id    <= '0;
            m_enable    <= 1'b0;
            m_reg_addr  <= '0;
            m_data      <= '0;
        end else begin
            state       <= state_nxt;
            timer       <= timer_nxt;
            gap_cnt     <= gap_cnt_nxt;
            ptr         <= ptr_nxt;
            ack         <= ack_nxt;
            ack_err     <= ack_err_nxt;
            timeout_err <= terr_nxt;
            busy        <= busy_nxt;
            grant_id    <= gid_nxt;
            m_enable    <= en_nxt;
            m_reg_addr  <= addr_nxt;
            m_data      <= data_nxt;
        end
    end

endmodule
